// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - APB phase encodings shared by the arbiter and the completer
package apb_pkg;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] SETUP  = 2'b01;
    localparam logic [1:0] ACCESS = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = IDLE,
        ST_SETUP  = SETUP,
        ST_ACCESS = ACCESS
    } apb_state_e;

    // Round-robin successor: the requester after idx becomes highest priority.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/apb_master_arbiter_if.sv
// rtl/apb_master_arbiter_if.sv - APB bus between the arbiter (master) and the completer (slave)
interface apb_master_arbiter_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic                  pready;
    logic                  pslverr;
    logic [DATA_WIDTH-1:0] prdata;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  pready, pslverr, prdata
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output pready, pslverr, prdata
    );
endinterface

// File: rtl/apb_rr_pick.sv
// rtl/apb_rr_pick.sv - combinational round-robin pick: first set request at or above the pointer
module apb_rr_pick #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       any
);
    localparam int IW = $clog2(NUM_REQ);

    int j;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (!any && req[j]) begin
                any      = 1'b1;
                idx      = IW'(j);
                grant[j] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - round-robin arbiter sharing one APB completer among NUM_REQ requesters
// Optional ACCESS-phase timeout enabled by defining APB_TIMEOUT_EN.
module apb_master_arbiter
    import apb_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                             pclk,
    input  logic                             prst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_err,
    apb_master_arbiter_if.master             apb
);
    localparam int IW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || TIMEOUT_CYC < 1) begin : g_cfg_check
        $error("apb_master_arbiter: NUM_REQ must be >= 2 and TIMEOUT_CYC >= 1");
    end

    apb_state_e            state_q, state_d;
    logic [IW-1:0]         ptr_q, ptr_d;
    logic [IW-1:0]         gidx_q, gidx_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [NUM_REQ-1:0]    req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
`ifdef APB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0]         tcnt_q, tcnt_d;
`endif

    logic [NUM_REQ-1:0]    busy_mask;
    logic [NUM_REQ-1:0]    pick_grant;
    logic [IW-1:0]         pick_idx;
    logic                  pick_any;
    logic                  do_grant;

    // The requester currently in ACCESS cannot win the re-arbitration at its own completion.
    always_comb begin
        busy_mask = '0;
        if (state_q == ST_ACCESS) begin
            busy_mask[gidx_q] = 1'b1;
        end
    end

    apb_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req   (req_valid & ~busy_mask),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gidx_d      = gidx_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        req_ready_d = '0;
        rsp_valid_d = '0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        do_grant    = 1'b0;
`ifdef APB_TIMEOUT_EN
        tcnt_d      = tcnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                do_grant = pick_any;
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
                tcnt_d    = '0;
`endif
            end
            ST_ACCESS: begin
                if (apb.pready) begin
                    rsp_valid_d[gidx_q] = 1'b1;
                    rsp_err_d           = apb.pslverr;
                    rsp_rdata_d         = pwrite_q ? '0 : apb.prdata;
                    if (pick_any) begin
                        do_grant = 1'b1;
                    end else begin
                        state_d   = ST_IDLE;
                        psel_d    = 1'b0;
                        penable_d = 1'b0;
                    end
                end
`ifdef APB_TIMEOUT_EN
                else if (tcnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    rsp_valid_d[gidx_q] = 1'b1;
                    rsp_err_d           = 1'b1;
                    state_d             = ST_IDLE;
                    psel_d              = 1'b0;
                    penable_d           = 1'b0;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d   = ST_IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase

        if (do_grant) begin
            state_d     = ST_SETUP;
            psel_d      = 1'b1;
            penable_d   = 1'b0;
            pwrite_d    = req_write[pick_idx];
            paddr_d     = req_addr[32'(pick_idx) * ADDR_WIDTH +: ADDR_WIDTH];
            pwdata_d    = req_wdata[32'(pick_idx) * DATA_WIDTH +: DATA_WIDTH];
            req_ready_d = pick_grant;
            gidx_d      = pick_idx;
            ptr_d       = IW'(rr_next(32'(pick_idx), NUM_REQ));
        end
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            gidx_q      <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
            tcnt_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gidx_q      <= gidx_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef APB_TIMEOUT_EN
            tcnt_q      <= tcnt_d;
`endif
        end
    end

    assign apb.psel    = psel_q;
    assign apb.penable = penable_q;
    assign apb.pwrite  = pwrite_q;
    assign apb.paddr   = paddr_q;
    assign apb.pwdata  = pwdata_q;
    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
endmodule
